// File: rtl/prefix_adder_pkg.sv
// rtl/prefix_adder_pkg.sv - shared types and helpers for the prefix adder pipeline
// Purpose: generate/propagate pair type, ceil-log2 helper and operation encodings
//          used by prefix_cell and prefix_adder_pipe.
package prefix_adder_pkg;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Ceil(log2(n)) for elaboration-time sizing; clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/prefix_cell.sv
// rtl/prefix_cell.sv - Kogge-Stone black cell combining two generate/propagate pairs
// Purpose: group (hi, lo) -> {g_hi | p_hi & g_lo, p_hi & p_lo}.
// Ports:
//   gp_hi_i  pair covering the more significant span
//   gp_lo_i  pair covering the adjacent less significant span
//   gp_o     combined pair for the union of both spans
module prefix_cell
  import prefix_adder_pkg::*;
(
  input  gp_t gp_hi_i,
  input  gp_t gp_lo_i,
  output gp_t gp_o
);

  assign gp_o.g = gp_hi_i.g | (gp_hi_i.p & gp_lo_i.g);
  assign gp_o.p = gp_hi_i.p & gp_lo_i.p;

endmodule

// File: rtl/prefix_adder_pipe.sv
// rtl/prefix_adder_pipe.sv - pipelined Kogge-Stone adder/subtractor with tag pass-through
// Purpose: one add/sub per cycle on a valid/ready handshake, NSTG-cycle latency,
//          bubble-collapsing backpressure and a synchronous flush.
// Optional feature: define PREFIX_ADDER_SAT_EN to enable signed saturation on in_sat.
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   flush                 squash every in-flight operation at the next edge
//   in_valid/in_ready     operation handshake
//   in_a, in_b            operands
//   in_sub, in_cin        subtract select (B inverted, carry-in 1) / carry-in for add
//   in_sat, in_tag        saturation request / tag copied to out_tag
//   out_valid/out_ready   result handshake
//   out_sum, out_cout     result and carry out of the MSB
//   out_ovf, out_zero     signed overflow of the unsaturated sum / result is zero
//   out_tag               tag of the result
module prefix_adder_pipe
  import prefix_adder_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int LVL_PER_STG = 2,
  parameter int TAG_W       = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_cin,
  input  logic             in_sat,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int NLVL = clog2(WIDTH);
  localparam int NPS  = (NLVL + LVL_PER_STG - 1) / LVL_PER_STG;  // prefix stages
  localparam int NSTG = NPS + 1;
  localparam int LAST = NSTG - 1;
  localparam int WP   = 1 << NLVL;                                // padded width

  // Handshake state
  logic [NSTG-1:0] v_q, v_d;
  logic [NSTG-1:0] adv;    // stage i hands its op onward this cycle
  logic [NSTG-1:0] space;  // stage i can be written this cycle
  logic            accept;

  // Stage 0..NPS-1 data; stage NPS is the output register set below
  logic [WP-1:0]    g_q   [NPS];
  logic [WP-1:0]    p_q   [NPS];
  logic [WIDTH-1:0] px_q  [NPS];  // bitwise a^b' kept for the final sum
  logic [TAG_W-1:0] tag_q [NPS];
  logic [NPS-1:0]   cin_q, amsb_q, bmsb_q, sat_q;

  logic [WIDTH-1:0] sum_q;
  logic             cout_q, ovf_q, zero_q;
  logic [TAG_W-1:0] otag_q;

  // Stage 0 combinational inputs
  logic [WIDTH-1:0] bx_d;
  logic             c0_d;
  logic [WP-1:0]    g0_d, p0_d;

  // Prefix network outputs per stage
  logic [WP-1:0] g_nx [1:NPS];
  logic [WP-1:0] p_nx [1:NPS];

  // Output stage combinational results
  logic [WIDTH-1:0] carry_d, sum_raw_d, sum_d;
  logic             ovf_d, zero_d, cout_d;

  // A stage has space when empty or when its op moves on; the walk runs from the
  // output backwards so a single stall point collapses bubbles upstream of it.
  always_comb begin
    adv         = '0;
    space       = '0;
    adv[LAST]   = v_q[LAST] & out_ready;
    space[LAST] = !v_q[LAST] | adv[LAST];
    for (int i = LAST - 1; i >= 0; i--) begin
      adv[i]   = v_q[i] & space[i+1];
      space[i] = !v_q[i] | adv[i];
    end
    v_d    = v_q;
    v_d[0] = space[0] ? in_valid : v_q[0];
    for (int i = 1; i <= LAST; i++) begin
      v_d[i] = space[i] ? v_q[i-1] : v_q[i];
    end
    if (flush) v_d = '0;
  end

  assign in_ready = space[0];
  assign accept   = in_valid & in_ready;

  // Carry-in is folded into bit 0's generate (g[-1] injection) so the prefix
  // tree stays clog2(WIDTH) levels deep; px keeps the raw propagate for the sum.
  always_comb begin
    bx_d = (in_sub == OP_ADD) ? in_b : ~in_b;
    c0_d = (in_sub == OP_SUB) ? 1'b1 : in_cin;
    g0_d = '0;
    p0_d = '0;
    g0_d[WIDTH-1:0] = in_a & bx_d;
    p0_d[WIDTH-1:0] = in_a ^ bx_d;
    g0_d[0] = g0_d[0] | (p0_d[0] & c0_d);
  end

  // Prefix stage k applies levels (k-1)*LVL_PER_STG .. k*LVL_PER_STG-1 to the
  // registers of stage k-1; levels past NLVL pass straight through.
  for (genvar k = 1; k <= NPS; k++) begin : g_stg
    for (genvar j = 0; j < LVL_PER_STG; j++) begin : g_lvl
      localparam int LVL = (k - 1) * LVL_PER_STG + j;
      logic [WP-1:0] gin, pin, go, po;

      if (j == 0) begin : g_src_reg
        assign gin = g_q[k-1];
        assign pin = p_q[k-1];
      end else begin : g_src_lvl
        assign gin = g_lvl[j-1].go;
        assign pin = g_lvl[j-1].po;
      end

      if (LVL < NLVL) begin : g_act
        localparam int SPAN = 1 << LVL;
        for (genvar i = 0; i < WP; i++) begin : g_bit
          if (i >= SPAN) begin : g_cell
            gp_t hi, lo, o;
            assign hi = {gin[i], pin[i]};
            assign lo = {gin[i-SPAN], pin[i-SPAN]};
            prefix_cell u_cell (
              .gp_hi_i (hi),
              .gp_lo_i (lo),
              .gp_o    (o)
            );
            assign go[i] = o.g;
            assign po[i] = o.p;
          end else begin : g_pass
            assign go[i] = gin[i];
            assign po[i] = pin[i];
          end
        end
      end else begin : g_idle
        assign go = gin;
        assign po = pin;
      end
    end

    assign g_nx[k] = g_lvl[LVL_PER_STG-1].go;
    assign p_nx[k] = g_lvl[LVL_PER_STG-1].po;
  end

  // Output stage: carry into bit i is the group generate of bits i-1..0.
  always_comb begin
    carry_d   = {g_nx[NPS][WIDTH-2:0], cin_q[NPS-1]};
    sum_raw_d = px_q[NPS-1] ^ carry_d;
    cout_d    = g_nx[NPS][WIDTH-1];
    ovf_d     = (amsb_q[NPS-1] == bmsb_q[NPS-1]) & (sum_raw_d[WIDTH-1] != amsb_q[NPS-1]);
    sum_d     = sum_raw_d;
`ifdef PREFIX_ADDER_SAT_EN
    if (sat_q[NPS-1] && ovf_d) begin
      sum_d = amsb_q[NPS-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
    zero_d = (sum_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int i = 0; i < NPS; i++) begin
        g_q[i]   <= '0;
        p_q[i]   <= '0;
        px_q[i]  <= '0;
        tag_q[i] <= '0;
      end
      cin_q  <= '0;
      amsb_q <= '0;
      bmsb_q <= '0;
      sat_q  <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      otag_q <= '0;
    end else begin
      v_q <= v_d;
      if (accept) begin
        g_q[0]    <= g0_d;
        p_q[0]    <= p0_d;
        px_q[0]   <= p0_d[WIDTH-1:0];
        tag_q[0]  <= in_tag;
        cin_q[0]  <= c0_d;
        amsb_q[0] <= in_a[WIDTH-1];
        bmsb_q[0] <= bx_d[WIDTH-1];
        sat_q[0]  <= in_sat;
      end
      for (int i = 1; i < NPS; i++) begin
        if (adv[i-1]) begin
          g_q[i]    <= g_nx[i];
          p_q[i]    <= p_nx[i];
          px_q[i]   <= px_q[i-1];
          tag_q[i]  <= tag_q[i-1];
          cin_q[i]  <= cin_q[i-1];
          amsb_q[i] <= amsb_q[i-1];
          bmsb_q[i] <= bmsb_q[i-1];
          sat_q[i]  <= sat_q[i-1];
        end
      end
      if (adv[LAST-1]) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
        otag_q <= tag_q[NPS-1];
      end
    end
  end

  assign out_valid = v_q[LAST];
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;
  assign out_zero  = zero_q;
  assign out_tag   = otag_q;

  // Padded top bits and final-level propagates have no consumer.
  logic unused_ok;
`ifdef PREFIX_ADDER_SAT_EN
  assign unused_ok = ^{g_nx[NPS], p_nx[NPS]};
`else
  assign unused_ok = ^{g_nx[NPS], p_nx[NPS], sat_q[NPS-1]};
`endif

endmodule
